// File: rtl/l2_arbiter.sv
// Shares one L2 line port between the I-cache and D-cache: one-cycle grant, command held until mem_resp, resp routed back combinationally.
// Contention is fixed-priority to D by default; define L2_ARB_ROUND_ROBIN_EN for alternating grants.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BE_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_byte_enable,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_byte_enable,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              read_q;
  logic              write_q;
  logic              d_req;
  logic              grant_d;

  assign d_req = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  // 0 = I-cache was granted last, 1 = D-cache.
  logic last_grant_q;
  assign grant_d = d_req & (~i_read | ~last_grant_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            // Read+write together is illegal; the write wins.
            addr_q  <= d_address;
            wdata_q <= d_wdata;
            be_q    <= d_byte_enable;
            write_q <= d_write;
            read_q  <= ~d_write;
            state_q <= SERVE_D;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
          end else if (i_read) begin
            addr_q  <= i_address;
            wdata_q <= '0;
            be_q    <= '1;
            write_q <= 1'b0;
            read_q  <= 1'b1;
            state_q <= SERVE_I;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign mem_read        = read_q;
  assign mem_write       = write_q;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_resp  = (state_q == SERVE_D) & mem_resp;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter; expectations follow the L2_ARB_ROUND_ROBIN_EN setting.
module tb_l2_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BE_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive point: 1 ns after the rising edge; checks follow after a further #2.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_WD = {8{32'hDEAD_BEEF}};
  localparam logic [ADDR_W-1:0] TIE_I_ADDR = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] TIE_D_ADDR = 32'h0000_2000;

  logic [3:0] exp_d_wins;

  initial begin
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_d_wins = 4'b0101;  // bit k = D wins tie k: D, I, D, I
`else
    exp_d_wins = 4'b1111;
`endif
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; d_byte_enable = '0; mem_rdata = '0; mem_resp = 0;
    next_cyc(); next_cyc();
    #2;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_byte_enable, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);

    // I-cache read
    next_cyc(); rst = 0; i_read = 1; i_address = 32'h0000_1040;
    next_cyc(); #2;
    chk("i_mem_read", mem_read, 1);
    chk("i_mem_write", mem_write, 0);
    chk("i_mem_address", mem_address, 32'h0000_1040);
    chk("i_mem_be", mem_byte_enable, 32'hFFFF_FFFF);
    mem_resp = 1; mem_rdata = PAT_A5; #2;
    chk("i_resp", i_resp, 1);
    chk("i_rdata", i_rdata, PAT_A5);
    chk("i_d_resp", d_resp, 0);
    next_cyc(); mem_resp = 0; i_read = 0; #2;
    chk("i_done_mem_read", mem_read, 0);
    chk("i_done_i_resp", i_resp, 0);
    next_cyc(); #2;
    chk("i_no_regrant", mem_read, 0);

    // D-cache write held through 5 wait cycles
    d_write = 1; d_address = 32'h8000_0020; d_byte_enable = 32'h0000_00FF; d_wdata = PAT_WD;
    next_cyc(); #2;
    chk("dw_mem_write", mem_write, 1);
    chk("dw_mem_read", mem_read, 0);
    for (int k = 0; k < 5; k++) begin
      next_cyc(); #2;
      chk("dw_hold_write", mem_write, 1);
      chk("dw_hold_addr", mem_address, 32'h8000_0020);
      chk("dw_hold_be", mem_byte_enable, 32'h0000_00FF);
      chk("dw_hold_wdata", mem_wdata, PAT_WD);
    end
    mem_resp = 1; #2;
    chk("dw_d_resp", d_resp, 1);
    chk("dw_i_resp", i_resp, 0);
    next_cyc(); mem_resp = 0; d_write = 0; #2;
    chk("dw_write_drop", mem_write, 0);
    chk("dw_d_resp_drop", d_resp, 0);

    // Latched command ignores later d_address changes
    next_cyc(); d_read = 1; d_address = 32'h100;
    next_cyc(); d_address = 32'h200; #2;
    chk("latch_addr0", mem_address, 32'h100);
    chk("latch_read", mem_read, 1);
    next_cyc(); #2;
    chk("latch_addr1", mem_address, 32'h100);
    mem_resp = 1; #2;
    chk("latch_d_resp", d_resp, 1);
    next_cyc(); mem_resp = 0; d_read = 0;

    // Contention after a fresh reset
    next_cyc(); rst = 1;
    next_cyc(); rst = 0; i_read = 1; i_address = TIE_I_ADDR; d_read = 1; d_address = TIE_D_ADDR;
    for (int k = 0; k < 4; k++) begin
      next_cyc(); #2;
      chk("tie_addr", mem_address, exp_d_wins[k] ? TIE_D_ADDR : TIE_I_ADDR);
      mem_resp = 1; #2;
      chk("tie_d_resp", d_resp, exp_d_wins[k]);
      chk("tie_i_resp", i_resp, !exp_d_wins[k]);
      next_cyc(); mem_resp = 0;
    end
    i_read = 0; d_read = 0;

    // Reset mid-SERVE_I drops the late response
    next_cyc(); i_read = 1; i_address = 32'h40;
    next_cyc(); #2;
    chk("rsv_mem_read", mem_read, 1);
    rst = 1; i_read = 0;
    next_cyc(); rst = 0; #2;
    chk("rsv_mem_read_clr", mem_read, 0);
    chk("rsv_mem_addr_clr", mem_address, 0);
    mem_resp = 1; #2;
    chk("rsv_i_resp", i_resp, 0);
    chk("rsv_d_resp", d_resp, 0);
    next_cyc(); mem_resp = 0; #2;
    chk("rsv_idle_read", mem_read, 0);
    chk("rsv_idle_write", mem_write, 0);

    // Spurious mem_resp in IDLE, then IDLE still grants normally
    mem_resp = 1; #2;
    chk("spur_i_resp", i_resp, 0);
    chk("spur_d_resp", d_resp, 0);
    next_cyc(); mem_resp = 0; #2;
    chk("spur_mem_read", mem_read, 0);
    d_read = 1; d_write = 1; d_address = 32'h300;
    next_cyc(); #2;
    chk("rw_is_write", mem_write, 1);
    chk("rw_not_read", mem_read, 0);
    chk("rw_addr", mem_address, 32'h300);
    mem_resp = 1; #2;
    chk("rw_d_resp", d_resp, 1);
    next_cyc(); mem_resp = 0; d_read = 0; d_write = 0; #2;
    chk("rw_done", mem_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
